// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency 256-bit line memory behind a cache refill port.
// Ports: clk_i, rst_i (async, active-low), mem_enable_i/mem_write_i/mem_addr_i/mem_data_i request,
//        mem_ack_o pulse, mem_data_o read line, mem_err_o out-of-range flag.
// Optional: define DATA_MEM_RESP_RANGE_CHECK_EN to flag and suppress accesses with addr[31:5] >= DEPTH.
module data_mem_responder #(
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         mem_enable_i,
  input  logic         mem_write_i,
  input  logic [31:0]  mem_addr_i,
  input  logic [255:0] mem_data_i,
  output logic         mem_ack_o,
  output logic [255:0] mem_data_o,
  output logic         mem_err_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_t;

  state_t         state;
  logic [7:0]     cnt;
  logic [AW-1:0]  cap_idx;
  logic           cap_write;
  logic           cap_oor;
  logic [255:0]   cap_data;

  logic [255:0]   mem [DEPTH];

  logic [AW-1:0]  req_idx;
  logic           req_oor;
  logic [AW-1:0]  ld_idx;
  logic           ld_oor;
  logic           ld_write;
  logic           enter_ack;
  logic           unused_addr;

  assign req_idx     = mem_addr_i[5 +: AW];
  assign unused_addr = ^{mem_addr_i[31:5+AW], mem_addr_i[4:0]};

`ifdef DATA_MEM_RESP_RANGE_CHECK_EN
  // DEPTH is a power of two, so any set bit above the index is out of range.
  assign req_oor = |mem_addr_i[31:5+AW];
`else
  assign req_oor = 1'b0;
`endif

  // With LATENCY=1 the ACK is entered straight from IDLE, before capture lands.
  assign ld_idx   = (state == IDLE) ? req_idx      : cap_idx;
  assign ld_oor   = (state == IDLE) ? req_oor      : cap_oor;
  assign ld_write = (state == IDLE) ? mem_write_i  : cap_write;

  assign enter_ack =
    ((state == IDLE) && mem_enable_i && (LATENCY == 1)) ||
    ((state == WAIT) && (cnt <= 8'd1));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      cnt        <= '0;
      cap_idx    <= '0;
      cap_write  <= 1'b0;
      cap_oor    <= 1'b0;
      cap_data   <= '0;
      mem_ack_o  <= 1'b0;
      mem_data_o <= '0;
    end else begin
      mem_ack_o <= enter_ack;
      if (enter_ack && !ld_write)
        mem_data_o <= ld_oor ? '0 : mem[ld_idx];
      unique case (state)
        IDLE: begin
          if (mem_enable_i) begin
            cap_idx   <= req_idx;
            cap_write <= mem_write_i;
            cap_oor   <= req_oor;
            cap_data  <= mem_data_i;
            if (LATENCY == 1) begin
              state <= ACK;
            end else begin
              state <= WAIT;
              cnt   <= 8'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (cnt <= 8'd1) begin
            state <= ACK;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ACK: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Commit on the edge closing ACK; reset forces IDLE so aborted writes never land.
  always_ff @(posedge clk_i) begin
    if ((state == ACK) && cap_write && !cap_oor)
      mem[cap_idx] <= cap_data;
  end

`ifdef DATA_MEM_RESP_RANGE_CHECK_EN
  logic err_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      err_q <= 1'b0;
    else
      err_q <= enter_ack && ld_oor;
  end

  assign mem_err_o = err_q;
`else
  assign mem_err_o = 1'b0;
`endif

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 512, meaning the number of 256-bit lines stored (power of two, 2..65536).
REQ-002 The block SHALL have parameter LATENCY, default 10, meaning the cycles from request acceptance to ack (1..255).
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port mem_enable_i, input, 1 bit: request valid from the cache.
REQ-006 The block SHALL have port mem_write_i, input, 1 bit: 1 = line write, 0 = line read.
REQ-007 The block SHALL have port mem_addr_i, input, 32 bits: byte address; bits [4:0] ignored.
REQ-008 The block SHALL have port mem_data_i, input, 256 bits: write line data.
REQ-009 The block SHALL have port mem_ack_o, output, 1 bit: one-cycle completion pulse.
REQ-010 The block SHALL have port mem_data_o, output, 256 bits: read line data.
REQ-011 The block SHALL have port mem_err_o, output, 1 bit: out-of-range flag, valid with ack.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, WAIT, ACK.
REQ-013 In IDLE with mem_enable_i=1 at a rising edge (cycle T), the block SHALL capture addr, write flag and data, and move to WAIT (LATENCY>1) or ACK (LATENCY=1).
REQ-014 In WAIT, a down-counter loaded with LATENCY-1 SHALL decrement each cycle; on reaching 1 the FSM SHALL move to ACK.
REQ-015 mem_ack_o SHALL be 1 only in ACK, i.e. exactly during cycle T+LATENCY, for exactly one cycle.
REQ-016 Line index SHALL be captured_addr[5+log2(DEPTH)-1:5].
REQ-017 A read SHALL drive mem_data_o with the indexed line during the ACK cycle, and SHALL hold it until the next read ack.
REQ-018 A write SHALL commit mem_data_i (as captured at T) to the indexed line at the edge ending the ACK cycle; mem_data_o SHALL be unchanged by writes.
REQ-019 Input changes while in WAIT or ACK SHALL be ignored; there is no queueing.
REQ-020 ACK SHALL always return to IDLE; if mem_enable_i is still 1 in the following IDLE cycle, that SHALL be accepted as a new request, so back-to-back requests are spaced LATENCY+1 cycles apart.
REQ-021 A read following a write to the same line SHALL return the written data.

Reset
REQ-022 While rst_i=0, the block SHALL force state IDLE, counter 0, mem_ack_o=0, mem_data_o=0 and mem_err_o=0, regardless of the clock.
REQ-023 Reset asserted mid-request SHALL abort the request with no ack, and a pending write SHALL NOT be committed.
REQ-024 Line contents SHALL NOT be cleared by reset.

Configuration
REQ-025 The macro DATA_MEM_RESP_RANGE_CHECK_EN SHALL control range checking.
REQ-026 With DATA_MEM_RESP_RANGE_CHECK_EN defined, a request whose mem_addr_i[31:5] >= DEPTH SHALL still ack at T+LATENCY with mem_err_o=1 in the ack cycle.
REQ-027 With DATA_MEM_RESP_RANGE_CHECK_EN defined, such an out-of-range read SHALL return all-zero data and such an out-of-range write SHALL be dropped.
REQ-028 With DATA_MEM_RESP_RANGE_CHECK_EN defined, mem_err_o SHALL be 0 in all cycles other than an out-of-range ack cycle.
REQ-029 Without DATA_MEM_RESP_RANGE_CHECK_EN, addresses SHALL wrap modulo DEPTH lines and mem_err_o SHALL be tied to 0.

Verification (DEPTH=512, LATENCY=10)
REQ-030 Bench SHALL cover: write addr 0x00000040, data {8{32'hA5A5_0001}} at T, then read 0x00000040 -> write ack at T+10, read ack 11 cycles after it, mem_data_o={8{32'hA5A5_0001}}.
REQ-031 Bench SHALL cover: read 0x00000045 after REQ-030 -> same line returned (bits [4:0] ignored).
REQ-032 Bench SHALL cover: mem_enable_i held high for 30 cycles, read at 0x0 -> acks at T+10 and T+21, single-cycle pulses.
REQ-033 Bench SHALL cover: write 0x00000080 with pattern B, rst_i=0 at T+5 -> no ack; after release, read 0x80 -> prior contents, not B.
REQ-034 Bench SHALL cover: mem_addr_i and mem_data_i changed at T+3 of a write -> the line captured at T is written to the address captured at T.
REQ-035 Bench SHALL cover: read 0x00004000 (line 512) -> with macro: ack at T+10, mem_err_o=1, data 0; without macro: data of line 0, mem_err_o=0.
